// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, single-outstanding instruction memory port and IF/ID output register.
// Stalls park a completed read in a hold buffer; redirects under a pending read drain the stale response first.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic [15:0] PC_plus_two,
  output logic [15:0] instruction,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] pc_next2;
  logic [15:0] hold_instr;
  logic [15:0] hold_pc2;
  logic [15:0] stale_addr;

  assign pc_next2 = pc + 16'd2;

  // While draining, the address must stay on the read the memory is still finishing.
  assign imem_req  = !rst && (state != S_HOLD);
  assign imem_addr = (state == S_DRAIN) ? stale_addr : pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      instruction <= NOP_INSTR;
      PC_plus_two <= 16'h0000;
      if_valid    <= 1'b0;
      hold_instr  <= 16'h0000;
      hold_pc2    <= 16'h0000;
      stale_addr  <= 16'h0000;
    end else if (branch_taken) begin
      instruction <= NOP_INSTR;
      if_valid    <= 1'b0;
      pc          <= branch_target;
      hold_instr  <= 16'h0000;
      hold_pc2    <= 16'h0000;
      if (state == S_REQ && !imem_ready) begin
        state      <= S_DRAIN;
        stale_addr <= pc;
      end else if (state == S_DRAIN) begin
        state <= S_DRAIN;
      end else begin
        state <= S_REQ;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (imem_ready) begin
            if (stall) begin
              hold_instr <= imem_rdata;
              hold_pc2   <= pc_next2;
              state      <= S_HOLD;
            end else begin
              instruction <= imem_rdata;
              PC_plus_two <= pc_next2;
              if_valid    <= 1'b1;
              pc          <= pc_next2;
            end
          end else if (!stall) begin
            instruction <= NOP_INSTR;
            if_valid    <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            instruction <= hold_instr;
            PC_plus_two <= hold_pc2;
            if_valid    <= 1'b1;
            pc          <= pc_next2;
            state       <= S_REQ;
          end
        end
        S_DRAIN: begin
          // pc already holds the redirect target; the stale word is simply dropped.
          if (imem_ready) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized stall/redirect/latency traffic
// against a behavioural memory and a flag-based fetch model.
module tb_instruction_fetch;

  localparam logic [15:0] RST_PC = 16'h0000;
  localparam logic [15:0] NOP    = 16'hE000;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, imem_req, imem_ready, if_valid;
  logic [15:0] branch_target, imem_addr, imem_rdata, PC_plus_two, instruction;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .PC_plus_two(PC_plus_two),
    .instruction(instruction), .if_valid(if_valid)
  );

  logic [15:0] mem [0:32767];
  int vectors = 0;
  int miscompares = 0;

  // Memory responder: one read at a time, latency mem_lat cycles (0 = random 1..4).
  bit          busy = 1'b0;
  int          remaining = 0;
  logic [15:0] lat_addr = 16'h0000;
  int          mem_lat = 1;
  int          starts = 0;
  int          addr_err = 0;
  logic [15:0] last_req_addr = 16'h0000;

  // Fetch model kept as flags: a word parked by a stall, or a stale read being discarded.
  logic [15:0] m_pc, m_instr, m_pc2, m_stale, m_buf_w, m_buf_p;
  bit          m_valid, m_buffered, m_draining;

  task automatic model_step();
    if (rst) begin
      m_pc = RST_PC; m_instr = NOP; m_pc2 = 16'h0000; m_valid = 1'b0;
      m_buffered = 1'b0; m_draining = 1'b0; m_stale = 16'h0000;
    end else if (branch_taken) begin
      if (!m_draining && !m_buffered && !imem_ready) begin
        m_draining = 1'b1;
        m_stale = m_pc;
      end
      m_buffered = 1'b0;
      m_pc = branch_target;
      m_instr = NOP;
      m_valid = 1'b0;
    end else if (m_draining) begin
      if (imem_ready) m_draining = 1'b0;
    end else if (m_buffered) begin
      if (!stall) begin
        m_instr = m_buf_w; m_pc2 = m_buf_p; m_valid = 1'b1;
        m_pc = m_pc + 16'd2; m_buffered = 1'b0;
      end
    end else if (imem_ready) begin
      if (stall) begin
        m_buffered = 1'b1; m_buf_w = imem_rdata; m_buf_p = m_pc + 16'd2;
      end else begin
        m_instr = imem_rdata; m_pc2 = m_pc + 16'd2; m_valid = 1'b1; m_pc = m_pc + 16'd2;
      end
    end else if (!stall) begin
      m_instr = NOP;
      m_valid = 1'b0;
    end
  endtask

  // One clock: drive inputs, let the memory respond, advance the model, sample 1 time unit after the edge.
  task automatic tick(input bit r, input bit s, input bit b, input logic [15:0] t, input bit late_rdy);
    bit req_seen;
    rst = r; stall = s; branch_taken = b; branch_target = t;
    #1;
    req_seen = imem_req;
    if (imem_req) begin
      last_req_addr = imem_addr;
      if (!busy) begin
        busy = 1'b1;
        lat_addr = imem_addr;
        remaining = (mem_lat > 0) ? mem_lat - 1 : int'($urandom_range(3, 0));
        starts++;
      end else if (imem_addr !== lat_addr) begin
        addr_err++;
      end
    end
    if (late_rdy) begin
      imem_ready = 1'b1; imem_rdata = 16'hBAD0;
    end else if (busy && remaining == 0) begin
      imem_ready = 1'b1; imem_rdata = mem[lat_addr[15:1]];
    end else begin
      imem_ready = 1'b0; imem_rdata = 16'hBAD1;
    end
    model_step();
    @(posedge clk);
    if (!req_seen || imem_ready) busy = 1'b0;
    else remaining--;
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 16'h0000, 0);
    tick(1, 1, 1, 16'h1234, 0);
    vectors++;
    if ({instruction, PC_plus_two, if_valid} !== {NOP, 16'h0000, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got %h/%h/%b want %h/0000/0", instruction, PC_plus_two, if_valid, NOP);
    end
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_req got %b want 0", imem_req);
    end
  endtask

  task automatic test_stream();
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem_lat = 1;
    tick(0, 0, 0, 16'h0000, 0);
    vectors++;
    if (last_req_addr !== RST_PC) begin
      miscompares++;
      $display("[TB] FAIL first_fetch_addr got %h want %h", last_req_addr, RST_PC);
    end
    vectors++;
    if ({instruction, PC_plus_two, if_valid} !== {16'h1111, 16'h0002, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL stream_1 got %h/%h/%b want 1111/0002/1", instruction, PC_plus_two, if_valid);
    end
    tick(0, 0, 0, 16'h0000, 0);
    vectors++;
    if ({instruction, PC_plus_two, if_valid} !== {16'h2222, 16'h0004, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL stream_2 got %h/%h/%b want 2222/0004/1", instruction, PC_plus_two, if_valid);
    end
  endtask

  task automatic test_stall_hold();
    int starts_before = starts;
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 16'h0000, 0);
      vectors++;
      if ({instruction, PC_plus_two, if_valid} !== {16'h2222, 16'h0004, 1'b1}) begin
        miscompares++;
        $display("[TB] FAIL stall_frozen cyc %0d got %h/%h/%b want 2222/0004/1", i, instruction, PC_plus_two, if_valid);
      end
    end
    tick(0, 0, 0, 16'h0000, 0);
    vectors++;
    if ({instruction, PC_plus_two, if_valid} !== {16'h3333, 16'h0006, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL stall_release got %h/%h/%b want 3333/0006/1", instruction, PC_plus_two, if_valid);
    end
    vectors++;
    if (starts - starts_before !== 1 || imem_addr !== 16'h0006) begin
      miscompares++;
      $display("[TB] FAIL stall_refetch reads %0d addr %h want 1 read, addr 0006", starts - starts_before, imem_addr);
    end
  endtask

  task automatic test_branch_over_stall();
    tick(0, 1, 1, 16'h0040, 0);
    vectors++;
    if ({instruction, if_valid, imem_req, imem_addr} !== {NOP, 1'b0, 1'b1, 16'h0040}) begin
      miscompares++;
      $display("[TB] FAIL branch_stall got %h/%b req %b addr %h want %h/0 req 1 addr 0040",
               instruction, if_valid, imem_req, imem_addr, NOP);
    end
  endtask

  task automatic test_drain();
    mem[4] = 16'h8888; mem[16'h0040] = 16'h8080;
    tick(0, 0, 1, 16'h0008, 0);
    mem_lat = 3;
    tick(0, 0, 0, 16'h0000, 0);
    tick(0, 0, 1, 16'h0080, 0);
    vectors++;
    if ({imem_req, imem_addr, if_valid} !== {1'b1, 16'h0008, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL drain_hold_addr got req %b addr %h valid %b want 1/0008/0", imem_req, imem_addr, if_valid);
    end
    tick(0, 0, 0, 16'h0000, 0);
    vectors++;
    if ({instruction, if_valid, imem_addr} !== {NOP, 1'b0, 16'h0080}) begin
      miscompares++;
      $display("[TB] FAIL drain_discard got %h/%b addr %h want %h/0 addr 0080", instruction, if_valid, imem_addr, NOP);
    end
    mem_lat = 1;
    tick(0, 0, 0, 16'h0000, 0);
    vectors++;
    if ({instruction, PC_plus_two, if_valid} !== {16'h8080, 16'h0082, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL drain_target_fetch got %h/%h/%b want 8080/0082/1", instruction, PC_plus_two, if_valid);
    end
  endtask

  task automatic test_wrap();
    mem[16'h7FFF] = 16'h7EEE;
    tick(0, 0, 1, 16'hFFFE, 0);
    tick(0, 0, 0, 16'h0000, 0);
    vectors++;
    if ({instruction, PC_plus_two, if_valid, imem_addr} !== {16'h7EEE, 16'h0000, 1'b1, 16'h0000}) begin
      miscompares++;
      $display("[TB] FAIL pc_wrap got %h/%h/%b addr %h want 7EEE/0000/1 addr 0000",
               instruction, PC_plus_two, if_valid, imem_addr);
    end
  endtask

  task automatic test_reset_mid_drain();
    mem_lat = 3;
    tick(0, 0, 0, 16'h0000, 0);
    tick(0, 0, 1, 16'h0100, 0);
    vectors++;
    if (imem_addr !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_drain addr got %h want 0000", imem_addr);
    end
    tick(1, 0, 0, 16'h0000, 1);
    tick(1, 0, 0, 16'h0000, 1);
    vectors++;
    if ({instruction, PC_plus_two, if_valid, imem_req} !== {NOP, 16'h0000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_drain got %h/%h/%b req %b want %h/0000/0 req 0",
               instruction, PC_plus_two, if_valid, imem_req, NOP);
    end
    mem_lat = 1;
    tick(0, 0, 0, 16'h0000, 0);
    vectors++;
    if ({last_req_addr, instruction, PC_plus_two, if_valid} !== {RST_PC, 16'h1111, 16'h0002, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL post_reset_fetch got addr %h %h/%h/%b want addr %h 1111/0002/1",
               last_req_addr, instruction, PC_plus_two, if_valid, RST_PC);
    end
  endtask

  task automatic test_random();
    logic [15:0] fetched_from;
    bit exp_req;
    mem_lat = 0;
    for (int i = 0; i < 800; i++) begin
      tick($urandom_range(63, 0) == 0, $urandom_range(3, 0) == 0, $urandom_range(7, 0) == 0,
           16'($urandom) & 16'hFFFE, 0);
      exp_req = !rst && !m_buffered;
      vectors++;
      if ({instruction, PC_plus_two, if_valid} !== {m_instr, m_pc2, m_valid}) begin
        miscompares++;
        $display("[TB] FAIL rand_outputs cyc %0d got %h/%h/%b want %h/%h/%b",
                 i, instruction, PC_plus_two, if_valid, m_instr, m_pc2, m_valid);
      end
      vectors++;
      if (imem_req !== exp_req || (exp_req && imem_addr !== (m_draining ? m_stale : m_pc))) begin
        miscompares++;
        $display("[TB] FAIL rand_fetch cyc %0d got req %b addr %h want req %b addr %h",
                 i, imem_req, imem_addr, exp_req, m_draining ? m_stale : m_pc);
      end
      if (if_valid === 1'b1) begin
        fetched_from = PC_plus_two - 16'd2;
        vectors++;
        if (instruction !== mem[fetched_from[15:1]]) begin
          miscompares++;
          $display("[TB] FAIL rand_program_word cyc %0d got %h want %h (addr %h)",
                   i, instruction, mem[fetched_from[15:1]], fetched_from);
        end
      end
    end
    vectors++;
    if (addr_err !== 0) begin
      miscompares++;
      $display("[TB] FAIL addr_stable got %0d address changes under pending reads want 0", addr_err);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    imem_ready = 1'b0; imem_rdata = 16'h0000;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    test_reset();
    test_stream();
    test_stall_hold();
    test_branch_over_stall();
    test_drain();
    test_wrap();
    test_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock port clk, reset port rst.
REQ-002 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-003 Parameter NOP_INSTR, default 16'h0000: instruction word emitted on bubbles and flushes.
REQ-004 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 stall  in  1  hazard hold from decode; the IF/ID register holds its value this cycle.
REQ-007 branch_taken  in  1  redirect request; highest priority after rst.
REQ-008 branch_target  in  16  redirect PC, sampled when branch_taken=1.
REQ-009 imem_req  out  1  instruction memory read request.
REQ-010 imem_addr  out  16  fetch address; stable while imem_req=1 and imem_ready=0.
REQ-011 imem_rdata  in  16  instruction word, valid when imem_ready=1.
REQ-012 imem_ready  in  1  read complete; single outstanding request, latency of 1..N cycles.
REQ-013 PC_plus_two  out  16  registered address of the fetched instruction + 2, to IF/ID.
REQ-014 instruction  out  16  registered fetched instruction, to IF/ID.
REQ-015 if_valid  out  1  registered; 1 = instruction/PC_plus_two hold a real fetch.

Function
REQ-016 The block SHALL hold a 16-bit PC register and a 3-state FSM: S_REQ (fetch at PC), S_HOLD (word buffered during stall), S_DRAIN (discard a stale in-flight read).
REQ-017 PC arithmetic SHALL be 16-bit modulo 2^16; 16'hFFFE + 2 SHALL wrap to 16'h0000 with no flag.
REQ-018 In S_REQ: imem_req=1, imem_addr=PC. In S_DRAIN: imem_req=1, imem_addr=the stale address. In S_HOLD: imem_req=0.
REQ-019 S_REQ, imem_ready=1, stall=0, branch_taken=0: instruction<=imem_rdata, PC_plus_two<=PC+2, if_valid<=1, PC<=PC+2, stay in S_REQ; sustained throughput is 1 instruction/cycle with a 1-cycle memory.
REQ-020 S_REQ, imem_ready=1, stall=1: save imem_rdata and PC+2 in the hold buffer, outputs unchanged, PC unchanged, go to S_HOLD.
REQ-021 S_HOLD, stall=0: load the buffered word to outputs, if_valid<=1, PC<=PC+2, go to S_REQ; S_HOLD, stall=1: remain in S_HOLD, outputs unchanged.
REQ-022 S_REQ, imem_ready=0, stall=0: bubble, instruction<=NOP_INSTR, if_valid<=0, PC_plus_two unchanged.
REQ-023 Any state, stall=1 with no other event: instruction, PC_plus_two and if_valid SHALL NOT change.
REQ-024 branch_taken=1 SHALL override stall: instruction<=NOP_INSTR, if_valid<=0, PC<=branch_target, and the hold buffer is discarded.
REQ-025 Redirect in S_REQ with imem_ready=1, or in S_HOLD: discard any data and go to S_REQ; the fetch at branch_target starts next cycle.
REQ-026 Redirect in S_REQ with imem_ready=0: go to S_DRAIN, keep imem_addr at the stale address until imem_ready=1, discard that data, then go to S_REQ.
REQ-027 Redirect in S_DRAIN: replace the pending target with the new branch_target and stay in S_DRAIN.
REQ-028 S_DRAIN, imem_ready=1 without a new redirect: go to S_REQ; outputs stay NOP_INSTR / if_valid=0 throughout the drain.
REQ-029 imem_addr SHALL NOT change while imem_req=1 and imem_ready=0.

Reset
REQ-030 rst=1 at a clock edge SHALL set PC=RESET_PC, state=S_REQ, instruction=NOP_INSTR, PC_plus_two=16'h0000, if_valid=0, and clear the hold buffer and pending target, overriding all other inputs.
REQ-031 imem_req SHALL be 0 while rst=1; the first request (imem_addr=RESET_PC) SHALL occur in the first cycle after rst deasserts.
REQ-032 Reset during S_DRAIN or S_HOLD SHALL abandon the in-flight read; any imem_ready that arrives later for the abandoned read SHALL be ignored.

Verification
REQ-033 Stream, 1-cycle memory, rdata=16'h1111,16'h2222 -> instruction 1111/PC_plus_two 0002, then 2222/0004, if_valid=1 on consecutive cycles.
REQ-034 Stall for 3 cycles while imem_ready=1 at PC=0004 -> outputs frozen 3 cycles, then buffered word with PC_plus_two=0006, no re-fetch of 0004.
REQ-035 branch_taken with target 16'h0040 and stall=1 in the same cycle -> if_valid=0, instruction=NOP_INSTR, next imem_addr=0040.
REQ-036 Redirect to 16'h0080 while a 3-cycle read of 0008 is pending -> imem_addr holds 0008 until ready, its data is discarded, then imem_addr=0080.
REQ-037 PC=16'hFFFE fetch -> PC_plus_two=16'h0000, next imem_addr=16'h0000.
REQ-038 rst asserted mid-drain, late imem_ready follows -> all outputs at reset values, first fetch at RESET_PC, late data never appears on instruction.
